// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency unified memory port between instruction fetch and the
// data-memory stage. MEM wins over IF; each access runs IDLE -> BUSY -> DONE.
module mem_port_arbiter #(
  parameter int WORD_LEN    = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [WORD_LEN-1:0] if_addr,
  output logic [WORD_LEN-1:0] if_instr,
  output logic                if_ready,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [WORD_LEN-1:0] mem_addr,
  input  logic [WORD_LEN-1:0] mem_wdata,
  output logic [WORD_LEN-1:0] mem_rdata,
  output logic                mem_ready,
  output logic                freeze_if,
  output logic                freeze_pipe,
  output logic                ext_en,
  output logic                ext_we,
  output logic [WORD_LEN-1:0] ext_addr,
  output logic [WORD_LEN-1:0] ext_wdata,
  input  logic [WORD_LEN-1:0] ext_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [WORD_LEN-1:0] addr_q, addr_d;
  logic [WORD_LEN-1:0] wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [WORD_LEN-1:0] if_instr_q, if_instr_d;
  logic [WORD_LEN-1:0] mem_rdata_q, mem_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                mem_ready_q, mem_ready_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_instr_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      if_instr_q  <= if_instr_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    if_instr_d  = if_instr_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        owner_d = OWN_NONE;
        // The older instruction in MEM always goes first.
        if (mem_rd || mem_wr) begin
          owner_d = OWN_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_wr;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end else if (if_req) begin
          owner_d = OWN_IF;
          addr_d  = if_addr;
          wdata_d = mem_wdata;
          we_d    = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          if (owner_q == OWN_IF) begin
            if_instr_d = ext_rdata;
            if_ready_d = 1'b1;
          end else if (owner_q == OWN_MEM) begin
            mem_ready_d = 1'b1;
            if (!we_q) mem_rdata_d = ext_rdata;
          end
        end
      end
      S_DONE: begin
        // No grant here: the requester must advance before being re-sampled.
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  assign ext_en      = (state_q == S_BUSY);
  assign ext_we      = (state_q == S_BUSY) && we_q;
  assign ext_addr    = addr_q;
  assign ext_wdata   = wdata_q;
  assign if_instr    = if_instr_q;
  assign if_ready    = if_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign mem_ready   = mem_ready_q;
  assign freeze_pipe = (mem_rd || mem_wr) && !mem_ready_q;
  assign freeze_if   = (if_req && !if_ready_q) || freeze_pipe;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (latency 2, 1, 4) with shared directed stimulus; a transaction-level
// model checks every output each cycle, and literal expectations pin the key timings.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, if_req, mem_rd, mem_wr;
  logic [15:0] if_addr, mem_addr, mem_wdata;

  logic [2:0]  if_ready_w, mem_ready_w, freeze_if_w, freeze_pipe_w, ext_en_w, ext_we_w;
  logic [15:0] if_instr_w [3];
  logic [15:0] mem_rdata_w [3];
  logic [15:0] ext_addr_w [3];
  logic [15:0] ext_wdata_w [3];
  logic [15:0] ext_rdata_w [3];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(int a);
    return (a == 4) ? 16'hA5A5 : {8'hC0, 8'(a)};
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
    end
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
      logic [15:0] mem [256];

      // External memory: reloaded on reset, written while the port is enabled for a store.
      always @(posedge clk) begin
        if (rst) begin
          for (int a = 0; a < 256; a++) mem[a] <= init_val(a);
        end else if (ext_en_w[gi] && ext_we_w[gi]) begin
          mem[ext_addr_w[gi][7:0]] <= ext_wdata_w[gi];
        end
      end
      assign ext_rdata_w[gi] = mem[ext_addr_w[gi][7:0]];

      mem_port_arbiter #(.WORD_LEN(16), .MEM_LATENCY(LAT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_instr   (if_instr_w[gi]),
        .if_ready   (if_ready_w[gi]),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata_w[gi]),
        .mem_ready  (mem_ready_w[gi]),
        .freeze_if  (freeze_if_w[gi]),
        .freeze_pipe(freeze_pipe_w[gi]),
        .ext_en     (ext_en_w[gi]),
        .ext_we     (ext_we_w[gi]),
        .ext_addr   (ext_addr_w[gi]),
        .ext_wdata  (ext_wdata_w[gi]),
        .ext_rdata  (ext_rdata_w[gi])
      );
    end
  endgenerate

  // Transaction-level model: an access granted at cycle g is on the port for cycles
  // g+1..g+L, completes at g+L+1, and the next grant can happen no earlier than g+L+2.
  bit          started = 0;
  bit          act_m [3];
  int          g_m [3];
  int          own_m [3];
  logic [15:0] ta_m [3];
  logic [15:0] tw_m [3];
  bit          twe_m [3];
  logic [15:0] ins_m [3];
  logic [15:0] rd_m [3];
  logic [15:0] mm [3][256];
  bit          post_rst [3];

  always @(negedge clk) begin : p_model
    int L;
    bit en_e, done_e, ifr_e, mr_e, fp_e, fi_e, idle_now;
    for (int k = 0; k < 3; k++) begin
      L      = lat_of(k);
      en_e   = act_m[k] && (cyc >= g_m[k] + 1) && (cyc <= g_m[k] + L);
      done_e = act_m[k] && (cyc == g_m[k] + L + 1);
      ifr_e  = done_e && (own_m[k] == 1);
      mr_e   = done_e && (own_m[k] == 2);
      if (started) begin
        if (done_e) begin
          if (!twe_m[k]) begin
            if (own_m[k] == 1) ins_m[k] = mm[k][ta_m[k][7:0]];
            else rd_m[k] = mm[k][ta_m[k][7:0]];
          end
          $display("txn L=%0d %s %s addr=%h done cycle=%0d", L, (own_m[k] == 1) ? "IF " : "MEM",
                   twe_m[k] ? "wr" : "rd", ta_m[k], cyc);
        end
        fp_e = (mem_rd || mem_wr) && !mr_e;
        fi_e = (if_req && !ifr_e) || fp_e;
        chk($sformatf("L%0d ext_en", L), ext_en_w[k], en_e);
        chk($sformatf("L%0d ext_we", L), ext_we_w[k], en_e && twe_m[k]);
        chk($sformatf("L%0d if_ready", L), if_ready_w[k], ifr_e);
        chk($sformatf("L%0d mem_ready", L), mem_ready_w[k], mr_e);
        chk($sformatf("L%0d if_instr", L), if_instr_w[k], ins_m[k]);
        chk($sformatf("L%0d mem_rdata", L), mem_rdata_w[k], rd_m[k]);
        chk($sformatf("L%0d freeze_pipe", L), freeze_pipe_w[k], fp_e);
        chk($sformatf("L%0d freeze_if", L), freeze_if_w[k], fi_e);
        if (en_e) begin
          chk($sformatf("L%0d ext_addr", L), ext_addr_w[k], ta_m[k]);
          if (twe_m[k]) chk($sformatf("L%0d ext_wdata", L), ext_wdata_w[k], tw_m[k]);
        end
        if (post_rst[k]) begin
          chk($sformatf("L%0d ext_addr after reset", L), ext_addr_w[k], 16'h0);
          chk($sformatf("L%0d ext_wdata after reset", L), ext_wdata_w[k], 16'h0);
        end
      end
      post_rst[k] = 0;
      if (rst) begin
        act_m[k] = 0;
        ins_m[k] = '0;
        rd_m[k]  = '0;
        post_rst[k] = started;
        for (int a = 0; a < 256; a++) mm[k][a] = init_val(a);
      end else if (started) begin
        idle_now = !act_m[k];
        if (done_e) act_m[k] = 0;
        if (idle_now) begin
          if (mem_rd || mem_wr) begin
            act_m[k] = 1; g_m[k] = cyc; own_m[k] = 2;
            ta_m[k] = mem_addr; tw_m[k] = mem_wdata; twe_m[k] = mem_wr;
            if (mem_wr) mm[k][mem_addr[7:0]] = mem_wdata;
          end else if (if_req) begin
            act_m[k] = 1; g_m[k] = cyc; own_m[k] = 1;
            ta_m[k] = if_addr; tw_m[k] = mem_wdata; twe_m[k] = 0;
          end
        end
      end
    end
    if (rst) started = 1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int n);
    repeat (n) next_cycle();
  endtask

  initial begin
    int first [3];
    int encnt [3];
    int rcnt;
    rst = 1'b1; if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset if_ready", if_ready_w[0], 1'b0);
    chk("reset ext_en", ext_en_w[0], 1'b0);
    next_cycle();

    // Fetch of 0x0004.
    for (int i = 0; i < 5; i++) begin
      if_req = (i < 4); if_addr = 16'h0004;
      @(negedge clk);
      chk($sformatf("fetch if_ready c%0d", i), if_ready_w[0], i == 3);
      chk($sformatf("fetch ext_en c%0d", i), ext_en_w[0], (i == 1) || (i == 2));
      chk($sformatf("fetch freeze_if c%0d", i), freeze_if_w[0], i <= 2);
      if (i == 3) chk("fetch if_instr", if_instr_w[0], 16'hA5A5);
      next_cycle();
    end
    drain(8);

    // Store 0x1234 to 0x0010, then load it back.
    for (int i = 0; i < 5; i++) begin
      mem_wr = (i < 4); mem_addr = 16'h0010; mem_wdata = 16'h1234;
      @(negedge clk);
      chk($sformatf("store ext_we c%0d", i), ext_we_w[0], (i == 1) || (i == 2));
      chk($sformatf("store mem_ready c%0d", i), mem_ready_w[0], i == 3);
      next_cycle();
    end
    mem_wdata = 16'h0;
    drain(8);
    for (int i = 0; i < 5; i++) begin
      mem_rd = (i < 4); mem_addr = 16'h0010;
      @(negedge clk);
      chk($sformatf("load mem_ready c%0d", i), mem_ready_w[0], i == 3);
      if (i == 3) chk("load mem_rdata", mem_rdata_w[0], 16'h1234);
      next_cycle();
    end
    drain(8);

    // IF and MEM request together: MEM first, IF right after the idle gap.
    for (int i = 0; i < 9; i++) begin
      mem_rd = (i < 4); mem_addr = 16'h0030;
      if_req = (i < 8); if_addr = 16'h0020;
      @(negedge clk);
      chk($sformatf("conflict mem_ready c%0d", i), mem_ready_w[0], i == 3);
      chk($sformatf("conflict if_ready c%0d", i), if_ready_w[0], i == 7);
      chk($sformatf("conflict freeze_if c%0d", i), freeze_if_w[0], i <= 6);
      chk($sformatf("conflict freeze_pipe c%0d", i), freeze_pipe_w[0], i <= 2);
      if (i == 3) chk("conflict mem_rdata", mem_rdata_w[0], 16'hC030);
      if (i == 7) chk("conflict if_instr", if_instr_w[0], 16'hC020);
      next_cycle();
    end
    drain(10);

    // Reset in the middle of a store: no ready pulse, everything cleared.
    for (int i = 0; i < 6; i++) begin
      mem_wr = (i == 0); mem_addr = 16'h0040; mem_wdata = 16'hBEEF;
      rst = (i == 1);
      @(negedge clk);
      chk($sformatf("abort mem_ready c%0d", i), mem_ready_w[0], 1'b0);
      if (i == 1) chk("abort ext_we busy", ext_we_w[0], 1'b1);
      if (i == 2) begin
        chk("abort ext_en", ext_en_w[0], 1'b0);
        chk("abort ext_we", ext_we_w[0], 1'b0);
        chk("abort ext_addr", ext_addr_w[0], 16'h0);
        chk("abort ext_wdata", ext_wdata_w[0], 16'h0);
        chk("abort if_instr", if_instr_w[0], 16'h0);
        chk("abort mem_rdata", mem_rdata_w[0], 16'h0);
        chk("abort if_ready", if_ready_w[0], 1'b0);
      end
      next_cycle();
    end
    mem_wdata = 16'h0;
    drain(4);

    // Latency sweep: first ready at t+L+1, ext_en high L cycles before it.
    for (int k = 0; k < 3; k++) begin first[k] = -1; encnt[k] = 0; end
    for (int i = 0; i < 7; i++) begin
      if_req = (i < 6); if_addr = 16'h0004;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (first[k] < 0 && if_ready_w[k]) first[k] = i;
        if (first[k] < 0 && ext_en_w[k]) encnt[k]++;
      end
      next_cycle();
    end
    chk("sweep L1 ready cycle", 32'(first[1]), 32'd2);
    chk("sweep L4 ready cycle", 32'(first[2]), 32'd5);
    chk("sweep L1 ext_en cycles", 32'(encnt[1]), 32'd1);
    chk("sweep L4 ext_en cycles", 32'(encnt[2]), 32'd4);
    drain(10);

    // Fetch request withdrawn while busy: one ready pulse, then idle.
    rcnt = 0; encnt[0] = 0;
    for (int i = 0; i < 9; i++) begin
      if_req = (i == 0); if_addr = 16'h0008;
      @(negedge clk);
      if (if_ready_w[0]) rcnt++;
      if (ext_en_w[0]) encnt[0]++;
      if (i == 3) begin
        chk("withdraw if_ready", if_ready_w[0], 1'b1);
        chk("withdraw if_instr", if_instr_w[0], 16'hC008);
      end
      next_cycle();
    end
    chk("withdraw ready pulses", 32'(rcnt), 32'd1);
    chk("withdraw ext_en cycles", 32'(encnt[0]), 32'd2);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
